// File: rtl/key_evt_pkg.sv
// Shared types for the key event arbiter:
// event codes and per-key press states.
package key_evt_pkg;

  typedef enum logic [1:0] {
    EVT_CLICK        = 2'd0,
    EVT_LONG         = 2'd1,
    EVT_REPEAT       = 2'd2,
    EVT_LONG_RELEASE = 2'd3
  } evt_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } press_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_press_fsm.sv
// Per-key synchronizer, tick-rate debounce and
// press classifier producing one-cycle event posts.
module key_press_fsm
  import key_evt_pkg::*;
#(
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      key_raw,
  output logic      key_level,
  output logic      post,
  output evt_code_t post_code
);

  localparam int MAXT = max2(LONG_TICKS, REPEAT_TICKS);
  localparam int CW   = (MAXT > 2) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  logic sync1;
  logic sync2;
  logic samp;
  press_state_t state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      samp      <= 1'b0;
      key_level <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (tick) begin
        samp <= sync2;
        // level follows only two agreeing tick samples
        if (sync2 == samp) key_level <= sync2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (key_level) begin
            state <= PRESS;
            cnt   <= '0;
          end
        end
        PRESS: begin
          if (!key_level) begin
            state <= IDLE;
          end else if (cnt == LONG_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_level) begin
            state <= IDLE;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    post      = 1'b0;
    post_code = EVT_CLICK;
    if (tick) begin
      case (state)
        PRESS: begin
          if (!key_level) begin
            post      = 1'b1;
            post_code = EVT_CLICK;
          end else if (cnt == LONG_LAST) begin
            post      = 1'b1;
            post_code = EVT_LONG;
          end
        end
        HELD: begin
          if (!key_level) begin
            post      = 1'b1;
            post_code = EVT_LONG_RELEASE;
          end else if (cnt == REP_LAST) begin
            post      = 1'b1;
            post_code = EVT_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Key controller top: scan divider, per-key FSMs,
// pending slots and round-robin event output.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 50,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_in,
  output logic [NUM_KEYS-1:0]         key_level,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic [1:0]                  evt_code,
  output logic [NUM_KEYS-1:0]         overrun
);

  localparam int KW       = $clog2(NUM_KEYS);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SW       = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] KEY_LAST  = KW'(NUM_KEYS - 1);

  logic [SW-1:0] scan_cnt;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_cnt <= '0;
    else if (tick) scan_cnt <= '0;
    else scan_cnt <= scan_cnt + 1'b1;
  end

  assign tick = (scan_cnt == SCAN_LAST);

  logic [NUM_KEYS-1:0] post;
  evt_code_t           post_code [NUM_KEYS];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_press_fsm #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .key_raw  (key_in[k]),
      .key_level(key_level[k]),
      .post     (post[k]),
      .post_code(post_code[k])
    );
  end

  logic [NUM_KEYS-1:0] pend_v;
  evt_code_t           pend_code [NUM_KEYS];
  logic [KW-1:0]       rr_ptr;
  logic [KW-1:0]       rr_next;
  logic [KW-1:0]       grant;
  logic                grant_any;
  logic                load;
  logic [NUM_KEYS-1:0] clr;

  assign load = !evt_valid || evt_ready;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
      if (!grant_any && pend_v[KW'(idx)]) begin
        grant_any = 1'b1;
        grant     = KW'(idx);
      end
    end
  end

  always_comb begin
    clr = '0;
    if (load && grant_any) clr[grant] = 1'b1;
    rr_next = (grant == KEY_LAST) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v  <= '0;
      overrun <= '0;
      for (int k = 0; k < NUM_KEYS; k++) pend_code[k] <= EVT_CLICK;
    end else begin
      overrun <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        // a slot being drained this cycle can take the new post
        if (post[k]) begin
          if (pend_v[k] && !clr[k]) begin
            overrun[k] <= 1'b1;
          end else begin
            pend_v[k]    <= 1'b1;
            pend_code[k] <= post_code[k];
          end
        end else if (clr[k]) begin
          pend_v[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_code  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= grant_any;
      if (grant_any) begin
        evt_key  <= grant;
        evt_code <= pend_code[grant];
        rr_ptr   <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed self-checking bench for key_event_arbiter
// with SCAN_DIV=10, LONG_TICKS=5, REPEAT_TICKS=2.
module tb_key_event_arbiter;
  import key_evt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = '0;
  logic [3:0] key_level;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [1:0] evt_key;
  logic [1:0] evt_code;
  logic [3:0] overrun;

  key_event_arbiter #(
    .NUM_KEYS    (4),
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .LONG_TICKS  (5),
    .REPEAT_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_level(key_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_code (evt_code),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;
  int ev_key[$];
  int ev_code[$];
  int ev_t[$];
  int ovr_cnt = 0;
  int ovr_other = 0;

  // cyc mirrors the scan phase: ticks act on edges with cyc%10==0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        ev_key.push_back(int'(evt_key));
        ev_code.push_back(int'(evt_code));
        ev_t.push_back(cyc);
      end
      if (overrun[1]) ovr_cnt++;
      if ((overrun & 4'b1101) != 4'b0000) ovr_other++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int ph);
    step(1);
    for (int i = 0; i < 10 && (cyc % 10) != ph; i++) step(1);
  endtask

  task automatic clear_q();
    ev_key.delete();
    ev_code.delete();
    ev_t.delete();
  endtask

  int rise;
  int hi;

  initial begin
    #23;
    chk("rst_key_level", 32'(key_level), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // click on key 1
    clear_q();
    wait_phase(6);
    key_in[1] = 1'b1;
    rise = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (rise == 0 && key_level[1]) rise = i;
    end
    chk("click_rise_cycle", 32'(rise), 14);
    step(20);
    key_in[1] = 1'b0;
    step(40);
    chk("click_count", 32'(ev_key.size()), 1);
    chk("click_key", 32'(ev_key[0]), 1);
    chk("click_code", 32'(ev_code[0]), 32'(EVT_CLICK));
    chk("click_level_low", 32'(key_level[1]), 0);

    // glitch on key 2 spanning one tick
    clear_q();
    wait_phase(6);
    key_in[2] = 1'b1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (key_level[2]) hi = 1;
    end
    key_in[2] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (key_level[2]) hi = 1;
    end
    chk("glitch_level", 32'(hi), 0);
    chk("glitch_events", 32'(ev_key.size()), 0);

    // long hold with repeats on key 0
    clear_q();
    wait_phase(6);
    key_in[0] = 1'b1;
    step(120);
    key_in[0] = 1'b0;
    step(40);
    chk("long_count", 32'(ev_key.size()), 5);
    chk("long_code0", 32'(ev_code[0]), 32'(EVT_LONG));
    chk("long_code1", 32'(ev_code[1]), 32'(EVT_REPEAT));
    chk("long_code2", 32'(ev_code[2]), 32'(EVT_REPEAT));
    chk("long_code3", 32'(ev_code[3]), 32'(EVT_REPEAT));
    chk("long_code4", 32'(ev_code[4]), 32'(EVT_LONG_RELEASE));
    chk("long_key", 32'(ev_key[0] | ev_key[4]), 0);
    chk("long_rep_gap1", 32'(ev_t[1] - ev_t[0]), 20);
    chk("long_rep_gap2", 32'(ev_t[2] - ev_t[1]), 20);
    chk("long_rep_gap3", 32'(ev_t[3] - ev_t[2]), 20);
    chk("long_rel_gap", 32'(ev_t[4] - ev_t[3]), 10);

    // arbitration from a fresh rr pointer
    rst_n = 1'b0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    evt_ready = 1'b0;
    wait_phase(6);
    key_in = 4'b1101;
    step(40);
    key_in = 4'b0000;
    step(30);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(evt_valid), 1);
      chk("stall_key", 32'(evt_key), 0);
      chk("stall_code", 32'(evt_code), 32'(EVT_CLICK));
      step(1);
    end
    evt_ready = 1'b1;
    step(5);
    chk("arb_count", 32'(ev_key.size()), 3);
    chk("arb_key0", 32'(ev_key[0]), 0);
    chk("arb_key1", 32'(ev_key[1]), 2);
    chk("arb_key2", 32'(ev_key[2]), 3);
    chk("arb_codes", 32'(ev_code[0] | ev_code[1] | ev_code[2]), 0);
    chk("arb_b2b_1", 32'(ev_t[1] - ev_t[0]), 1);
    chk("arb_b2b_2", 32'(ev_t[2] - ev_t[1]), 1);
    chk("arb_drained", 32'(evt_valid), 0);

    // overrun on key 1 while output stalled
    clear_q();
    ovr_cnt = 0;
    ovr_other = 0;
    evt_ready = 1'b0;
    wait_phase(6);
    key_in[1] = 1'b1;
    step(116);
    evt_ready = 1'b1;
    step(4);
    key_in[1] = 1'b0;
    step(40);
    chk("ovr_pulses", 32'(ovr_cnt), 1);
    chk("ovr_other_keys", 32'(ovr_other), 0);
    chk("ovr_count", 32'(ev_key.size()), 4);
    chk("ovr_first_long", 32'(ev_code[0]), 32'(EVT_LONG));
    chk("ovr_code1", 32'(ev_code[1]), 32'(EVT_REPEAT));
    chk("ovr_code2", 32'(ev_code[2]), 32'(EVT_REPEAT));
    chk("ovr_code3", 32'(ev_code[3]), 32'(EVT_LONG_RELEASE));
    chk("ovr_keys", 32'(ev_key[0] & ev_key[3]), 1);

    // reset while key 0 is held
    clear_q();
    evt_ready = 1'b0;
    wait_phase(6);
    key_in[0] = 1'b1;
    step(80);
    chk("rmh_pre_valid", 32'(evt_valid), 1);
    chk("rmh_pre_level", 32'(key_level[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rmh_valid", 32'(evt_valid), 0);
    chk("rmh_level", 32'(key_level), 0);
    step(3);
    evt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    step(85);
    chk("rmh_count", 32'(ev_key.size()), 1);
    chk("rmh_key", 32'(ev_key[0]), 0);
    chk("rmh_code", 32'(ev_code[0]), 32'(EVT_LONG));
    chk("rmh_time", 32'(ev_t[0]), 81);
    key_in[0] = 1'b0;
    step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
